// File: rtl/rm_slot_allocator.sv
// Allocates monitored loads/stores to overlapping slot windows across runtime-monitor lanes.
// Optional `RM_SLOT_ALLOC_PERF_EN adds perf counters. grant_itype_o encoding: 2'd1 = LW_RM, 2'd2 = SW_RM.
module rm_slot_allocator #(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned SLOTS_PER_LANE = 2,
  parameter int unsigned VLEN           = 64,
  parameter bit          MON_LOAD       = 1'b1,
  parameter bit          MON_STORE      = 1'b1,
  localparam int unsigned LW = $clog2(NUM_LANES),
  localparam int unsigned SW = $clog2(SLOTS_PER_LANE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [6:0]           req_opcode_i,
  input  logic [VLEN-1:0]      req_pc_i,
  input  logic                 flush_i,
  input  logic [NUM_LANES-1:0] lane_release_i,
  output logic                 grant_valid_o,
  output logic [LW-1:0]        grant_lane0_o,
  output logic [SW-1:0]        grant_slot0_o,
  output logic                 grant_two_lane_o,
  output logic [LW-1:0]        grant_lane1_o,
  output logic                 grant_last_o,
  output logic [1:0]           grant_itype_o,
  output logic [VLEN-1:0]      grant_pc_o,
  output logic [NUM_LANES-1:0] lane_busy_o,
  output logic [15:0]          overflow_cnt_o
`ifdef RM_SLOT_ALLOC_PERF_EN
  ,
  output logic [31:0]          perf_alloc_cnt_o,
  output logic [31:0]          perf_two_lane_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(SLOTS_PER_LANE + 1);

  localparam logic [1:0]    ST_FREE     = 2'd0;
  localparam logic [1:0]    ST_FILLING  = 2'd1;
  localparam logic [1:0]    ST_SEALED   = 2'd2;
  localparam logic [6:0]    OPC_LOAD    = 7'b0000011;
  localparam logic [6:0]    OPC_STORE   = 7'b0100011;
  localparam logic [1:0]    ITYPE_LW_RM = 2'd1;
  localparam logic [1:0]    ITYPE_SW_RM = 2'd2;
  localparam logic [CW-1:0] CNT_LAST    = CW'(SLOTS_PER_LANE - 1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(SLOTS_PER_LANE);

  logic [1:0]           state_q [NUM_LANES];
  logic [1:0]           state_d [NUM_LANES];
  logic [CW-1:0]        cnt_q   [NUM_LANES];
  logic [CW-1:0]        cnt_d   [NUM_LANES];
  logic                 open_vld_q, open_vld_d;
  logic [LW-1:0]        open_lane_q, open_lane_d;
  logic [NUM_LANES-1:0] pend_q, pend_d;

  logic                 is_load, is_store, mon_req, accept;
  logic                 free_any, seal, need_new;
  logic [LW-1:0]        free_lane;
  logic [CW-1:0]        open_cnt;
  logic [NUM_LANES-1:0] busy, busy_d, tgt, rel;

  logic                 gnt_valid_d, gnt_two_d, gnt_last_d;
  logic [LW-1:0]        gnt_lane0_d, gnt_lane1_d;
  logic [SW-1:0]        gnt_slot0_d;
  logic [1:0]           gnt_itype_d;
  logic [VLEN-1:0]      gnt_pc_d;
  logic [15:0]          ovf_d;

  // Next-state: releases first, then allocation on registered state
  always_comb begin
    is_load  = (req_opcode_i == OPC_LOAD);
    is_store = (req_opcode_i == OPC_STORE);
    mon_req  = req_valid_i & ((MON_LOAD & is_load) | (MON_STORE & is_store));

    busy      = '0;
    free_any  = 1'b0;
    free_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      busy[i] = (state_q[i] != ST_FREE);
      if (!busy[i]) begin
        free_any  = 1'b1;
        free_lane = LW'(i);
      end
    end

    open_cnt    = cnt_q[open_lane_q];
    seal        = open_vld_q & (open_cnt == CNT_LAST);
    need_new    = ~open_vld_q | seal;
    req_ready_o = ~need_new | free_any;
    accept      = mon_req & req_ready_o & ~flush_i;

    tgt = '0;
    if (accept) begin
      if (open_vld_q) tgt[open_lane_q] = 1'b1;
      if (need_new)   tgt[free_lane]   = 1'b1;
    end
    // Releases hitting a lane being allocated this cycle wait one cycle
    rel    = (lane_release_i | pend_q) & busy;
    pend_d = rel & tgt;

    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    open_vld_d  = open_vld_q;
    open_lane_d = open_lane_q;
    gnt_valid_d = 1'b0;
    gnt_lane0_d = grant_lane0_o;
    gnt_slot0_d = grant_slot0_o;
    gnt_two_d   = grant_two_lane_o;
    gnt_lane1_d = grant_lane1_o;
    gnt_last_d  = grant_last_o;
    gnt_itype_d = grant_itype_o;
    gnt_pc_d    = grant_pc_o;
    ovf_d       = overflow_cnt_o;

    for (int i = 0; i < NUM_LANES; i++) begin
      if (rel[i] && !tgt[i]) begin
        state_d[i] = ST_FREE;
        cnt_d[i]   = '0;
        if (open_vld_q && (open_lane_q == LW'(i))) open_vld_d = 1'b0;
      end
    end

    if (accept) begin
      gnt_valid_d = 1'b1;
      gnt_pc_d    = req_pc_i;
      gnt_itype_d = is_store ? ITYPE_SW_RM : ITYPE_LW_RM;
      gnt_two_d   = seal;
      gnt_last_d  = seal;
      gnt_lane1_d = seal ? free_lane : '0;
      if (!open_vld_q) begin
        gnt_lane0_d        = free_lane;
        gnt_slot0_d        = '0;
        state_d[free_lane] = ST_FILLING;
        cnt_d[free_lane]   = CW'(1);
        open_vld_d         = 1'b1;
        open_lane_d        = free_lane;
      end else begin
        gnt_lane0_d = open_lane_q;
        gnt_slot0_d = SW'(open_cnt);
        if (seal) begin
          state_d[open_lane_q] = ST_SEALED;
          cnt_d[open_lane_q]   = CNT_FULL;
          state_d[free_lane]   = ST_FILLING;
          cnt_d[free_lane]     = CW'(1);
          open_lane_d          = free_lane;
        end else begin
          cnt_d[open_lane_q] = open_cnt + CW'(1);
        end
      end
    end

    if (mon_req && !flush_i && !req_ready_o && (overflow_cnt_o != 16'hFFFF))
      ovf_d = overflow_cnt_o + 16'd1;

    busy_d = '0;
    for (int i = 0; i < NUM_LANES; i++) busy_d[i] = (state_d[i] != ST_FREE);
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= ST_FREE;
        cnt_q[i]   <= '0;
      end
      open_vld_q       <= 1'b0;
      open_lane_q      <= '0;
      pend_q           <= '0;
      grant_valid_o    <= 1'b0;
      grant_lane0_o    <= '0;
      grant_slot0_o    <= '0;
      grant_two_lane_o <= 1'b0;
      grant_lane1_o    <= '0;
      grant_last_o     <= 1'b0;
      grant_itype_o    <= '0;
      grant_pc_o       <= '0;
      lane_busy_o      <= '0;
      overflow_cnt_o   <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      open_vld_q       <= open_vld_d;
      open_lane_q      <= open_lane_d;
      pend_q           <= pend_d;
      grant_valid_o    <= gnt_valid_d;
      grant_lane0_o    <= gnt_lane0_d;
      grant_slot0_o    <= gnt_slot0_d;
      grant_two_lane_o <= gnt_two_d;
      grant_lane1_o    <= gnt_lane1_d;
      grant_last_o     <= gnt_last_d;
      grant_itype_o    <= gnt_itype_d;
      grant_pc_o       <= gnt_pc_d;
      lane_busy_o      <= busy_d;
      overflow_cnt_o   <= ovf_d;
    end
  end

`ifdef RM_SLOT_ALLOC_PERF_EN
  // Wrapping allocation and two-lane grant counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_alloc_cnt_o    <= '0;
      perf_two_lane_cnt_o <= '0;
    end else begin
      if (accept)        perf_alloc_cnt_o    <= perf_alloc_cnt_o + 32'd1;
      if (accept && seal) perf_two_lane_cnt_o <= perf_two_lane_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rm_slot_allocator.sv
// Self-checking bench for rm_slot_allocator: directed scenarios plus randomized traffic vs a lane/window model.
module tb_rm_slot_allocator;

  localparam int NL  = 4;
  localparam int SL  = 2;
  localparam int VL  = 64;
  localparam int LW  = 2;
  localparam int SWW = 1;
  localparam int FW  = 2 * LW + SWW + 5 + VL;

  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_R  = 7'b0110011;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [6:0]    req_opcode_i = '0;
  logic [VL-1:0] req_pc_i = '0;
  logic          flush_i = 1'b0;
  logic [NL-1:0] lane_release_i = '0;
  logic          grant_valid_o;
  logic [LW-1:0] grant_lane0_o;
  logic [SWW-1:0] grant_slot0_o;
  logic          grant_two_lane_o;
  logic [LW-1:0] grant_lane1_o;
  logic          grant_last_o;
  logic [1:0]    grant_itype_o;
  logic [VL-1:0] grant_pc_o;
  logic [NL-1:0] lane_busy_o;
  logic [15:0]   overflow_cnt_o;
`ifdef RM_SLOT_ALLOC_PERF_EN
  logic [31:0]   perf_alloc_cnt_o;
  logic [31:0]   perf_two_lane_cnt_o;
`endif

  rm_slot_allocator #(.NUM_LANES(NL), .SLOTS_PER_LANE(SL), .VLEN(VL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i), .req_pc_i(req_pc_i),
    .flush_i(flush_i), .lane_release_i(lane_release_i),
    .grant_valid_o(grant_valid_o), .grant_lane0_o(grant_lane0_o),
    .grant_slot0_o(grant_slot0_o), .grant_two_lane_o(grant_two_lane_o),
    .grant_lane1_o(grant_lane1_o), .grant_last_o(grant_last_o),
    .grant_itype_o(grant_itype_o), .grant_pc_o(grant_pc_o),
    .lane_busy_o(lane_busy_o), .overflow_cnt_o(overflow_cnt_o)
`ifdef RM_SLOT_ALLOC_PERF_EN
    , .perf_alloc_cnt_o(perf_alloc_cnt_o), .perf_two_lane_cnt_o(perf_two_lane_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Model: per-lane status (0 free, 1 filling, 2 sealed), slots used, open window, deferred releases
  int  m_state [NL];
  int  m_used  [NL];
  int  m_open;
  bit  m_pend  [NL];
  int  m_ovf;
  bit  exp_ready, obs_ready;
  bit  e_gv, e_two, e_last;
  int  e_l0, e_s0, e_l1, e_itype;
  logic [VL-1:0] e_pc;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_state[i] = 0; m_used[i] = 0; m_pend[i] = 1'b0;
    end
    m_open = -1; m_ovf = 0; e_gv = 1'b0;
  endtask

  function automatic logic [NL-1:0] m_busy();
    logic [NL-1:0] b;
    for (int i = 0; i < NL; i++) b[i] = (m_state[i] != 0);
    return b;
  endfunction

  task automatic model_step(input bit rst, input bit v, input logic [6:0] opc,
                            input logic [VL-1:0] pc, input bit fl, input logic [NL-1:0] rel);
    bit mon, need_new, acc;
    int f, o;
    bit tgt [NL];
    mon = v && (opc == OPC_LD || opc == OPC_ST);
    o = m_open;
    need_new = (o < 0) || (m_used[o] == SL - 1);
    f = -1;
    for (int i = NL - 1; i >= 0; i--) if (m_state[i] == 0) f = i;
    exp_ready = !need_new || (f >= 0);
    if (rst) begin
      model_reset();
      return;
    end
    acc = mon && exp_ready && !fl;
    for (int i = 0; i < NL; i++) tgt[i] = 1'b0;
    if (acc && o >= 0) tgt[o] = 1'b1;
    if (acc && need_new) tgt[f] = 1'b1;
    if (mon && !fl && !exp_ready && m_ovf < 65535) m_ovf++;
    for (int i = 0; i < NL; i++) begin
      if ((rel[i] || m_pend[i]) && m_state[i] != 0) begin
        if (tgt[i]) m_pend[i] = 1'b1;
        else begin
          m_pend[i] = 1'b0; m_state[i] = 0; m_used[i] = 0;
          if (m_open == i) m_open = -1;
        end
      end else m_pend[i] = 1'b0;
    end
    e_gv = acc;
    if (acc) begin
      e_pc = pc;
      e_itype = (opc == OPC_ST) ? 2 : 1;
      e_two = need_new && (o >= 0);
      e_last = e_two;
      e_l1 = e_two ? f : 0;
      if (o < 0) begin
        e_l0 = f; e_s0 = 0; m_state[f] = 1; m_used[f] = 1; m_open = f;
      end else begin
        e_l0 = o; e_s0 = m_used[o];
        if (e_two) begin
          m_state[o] = 2; m_used[o] = SL; m_state[f] = 1; m_used[f] = 1; m_open = f;
        end else m_used[o]++;
      end
    end
  endtask

  // One clock: drive at negedge, sample ready before the edge, land on the next negedge
  task automatic cycle(input bit rst, input bit v, input logic [6:0] opc,
                       input logic [VL-1:0] pc, input bit fl, input logic [NL-1:0] rel);
    rst_i = rst; req_valid_i = v; req_opcode_i = opc; req_pc_i = pc;
    flush_i = fl; lane_release_i = rel;
    #1;
    obs_ready = req_ready_o;
    model_step(rst, v, opc, pc, fl, rel);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0; req_valid_i = 1'b0; flush_i = 1'b0; lane_release_i = '0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 7'd0, '0, 1'b0, '0);
    cycle(1'b1, 1'b1, OPC_LD, 64'h40, 1'b0, 4'b1111);
    n_cmp++;
    if (grant_valid_o !== 1'b0) begin
      n_err++; $display("FAIL reset_grant_valid: got %0b want 0", grant_valid_o);
    end
    n_cmp++;
    if ({grant_lane0_o, grant_slot0_o, grant_two_lane_o, grant_lane1_o, grant_last_o,
         grant_itype_o, grant_pc_o} !== '0) begin
      n_err++; $display("FAIL reset_grant_fields: lane0=%0h slot0=%0h itype=%0h pc=%0h want all 0",
                        grant_lane0_o, grant_slot0_o, grant_itype_o, grant_pc_o);
    end
    n_cmp++;
    if (lane_busy_o !== 4'b0000) begin
      n_err++; $display("FAIL reset_busy: got %b want 0000", lane_busy_o);
    end
    n_cmp++;
    if (overflow_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL reset_overflow: got %0d want 0", overflow_cnt_o);
    end
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %0b want 1", req_ready_o);
    end
  endtask

  task automatic test_single_store();
    cycle(1'b0, 1'b1, OPC_ST, 64'h8000_0000, 1'b0, '0);
    n_cmp++;
    if ({grant_valid_o, grant_lane0_o, grant_slot0_o, grant_two_lane_o, grant_itype_o} !==
        {1'b1, 2'd0, 1'b0, 1'b0, 2'd2}) begin
      n_err++; $display("FAIL store_grant: gv=%0b lane0=%0d slot0=%0d two=%0b itype=%0d want 1 0 0 0 2",
                        grant_valid_o, grant_lane0_o, grant_slot0_o, grant_two_lane_o, grant_itype_o);
    end
    n_cmp++;
    if (grant_pc_o !== 64'h8000_0000) begin
      n_err++; $display("FAIL store_pc: got %0h want 80000000", grant_pc_o);
    end
    n_cmp++;
    if (lane_busy_o !== 4'b0001) begin
      n_err++; $display("FAIL store_busy: got %b want 0001", lane_busy_o);
    end
    cycle(1'b0, 1'b0, 7'd0, '0, 1'b0, '0);
    n_cmp++;
    if (grant_valid_o !== 1'b0) begin
      n_err++; $display("FAIL store_pulse: grant_valid got %0b want 0", grant_valid_o);
    end
  endtask

  task automatic test_fill_lanes();
    int t_l0 [4] = '{0, 0, 1, 2};
    int t_s0 [4] = '{0, 1, 1, 1};
    bit t_tw [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int t_l1 [4] = '{0, 1, 2, 3};
    cycle(1'b1, 1'b0, 7'd0, '0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, OPC_LD, VL'(64'h1000 + 4 * k), 1'b0, '0);
      n_cmp++;
      if ({grant_valid_o, grant_lane0_o, grant_slot0_o, grant_two_lane_o, grant_lane1_o, grant_last_o} !==
          {1'b1, LW'(t_l0[k]), SWW'(t_s0[k]), t_tw[k], LW'(t_l1[k]), t_tw[k]}) begin
        n_err++; $display("FAIL fill_grant%0d: gv=%0b l0=%0d s0=%0d two=%0b l1=%0d last=%0b want 1 %0d %0d %0b %0d %0b",
                          k, grant_valid_o, grant_lane0_o, grant_slot0_o, grant_two_lane_o, grant_lane1_o,
                          grant_last_o, t_l0[k], t_s0[k], t_tw[k], t_l1[k], t_tw[k]);
      end
    end
    n_cmp++;
    if (lane_busy_o !== 4'b1111) begin
      n_err++; $display("FAIL fill_busy: got %b want 1111", lane_busy_o);
    end
    cycle(1'b0, 1'b1, OPC_LD, 64'h1010, 1'b0, '0);
    n_cmp++;
    if (obs_ready !== 1'b0) begin
      n_err++; $display("FAIL fill_ready_full: got %0b want 0", obs_ready);
    end
    n_cmp++;
    if ({grant_valid_o, overflow_cnt_o} !== {1'b0, 16'd1}) begin
      n_err++; $display("FAIL fill_overflow: gv=%0b ovf=%0d want 0 1", grant_valid_o, overflow_cnt_o);
    end
  endtask

  task automatic test_release_reuse();
    cycle(1'b0, 1'b0, 7'd0, '0, 1'b0, 4'b0001);
    n_cmp++;
    if (lane_busy_o !== 4'b1110) begin
      n_err++; $display("FAIL release_busy: got %b want 1110", lane_busy_o);
    end
    cycle(1'b0, 1'b1, OPC_LD, 64'h2000, 1'b0, '0);
    n_cmp++;
    if ({grant_valid_o, grant_lane0_o, grant_slot0_o, grant_two_lane_o, grant_lane1_o} !==
        {1'b1, 2'd3, 1'b1, 1'b1, 2'd0}) begin
      n_err++; $display("FAIL release_reuse: gv=%0b l0=%0d s0=%0d two=%0b l1=%0d want 1 3 1 1 0",
                        grant_valid_o, grant_lane0_o, grant_slot0_o, grant_two_lane_o, grant_lane1_o);
    end
  endtask

  task automatic test_deferred_release();
    cycle(1'b1, 1'b0, 7'd0, '0, 1'b0, '0);
    cycle(1'b0, 1'b1, OPC_LD, 64'h3000, 1'b0, '0);
    cycle(1'b0, 1'b1, OPC_LD, 64'h3004, 1'b0, '0);
    cycle(1'b0, 1'b1, OPC_ST, 64'h3008, 1'b0, 4'b0010);
    n_cmp++;
    if ({grant_valid_o, grant_lane0_o, grant_slot0_o, grant_lane1_o, lane_busy_o} !==
        {1'b1, 2'd1, 1'b1, 2'd2, 4'b0111}) begin
      n_err++; $display("FAIL deferred_grant: gv=%0b l0=%0d s0=%0d l1=%0d busy=%b want 1 1 1 2 0111",
                        grant_valid_o, grant_lane0_o, grant_slot0_o, grant_lane1_o, lane_busy_o);
    end
    cycle(1'b0, 1'b0, 7'd0, '0, 1'b0, '0);
    n_cmp++;
    if (lane_busy_o !== 4'b0101) begin
      n_err++; $display("FAIL deferred_free: got %b want 0101", lane_busy_o);
    end
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b1, OPC_LD, 64'h4000, 1'b1, '0);
    n_cmp++;
    if ({grant_valid_o, lane_busy_o, overflow_cnt_o} !== {1'b0, 4'b0101, 16'd0}) begin
      n_err++; $display("FAIL flush_nochange: gv=%0b busy=%b ovf=%0d want 0 0101 0",
                        grant_valid_o, lane_busy_o, overflow_cnt_o);
    end
    cycle(1'b0, 1'b1, OPC_LD, 64'h4004, 1'b0, '0);
    cycle(1'b0, 1'b1, OPC_LD, 64'h4008, 1'b0, '0);
    cycle(1'b0, 1'b1, OPC_ST, 64'h400c, 1'b1, '0);
    n_cmp++;
    if ({obs_ready, grant_valid_o, overflow_cnt_o} !== {1'b0, 1'b0, 16'd0}) begin
      n_err++; $display("FAIL flush_full: ready=%0b gv=%0b ovf=%0d want 0 0 0",
                        obs_ready, grant_valid_o, overflow_cnt_o);
    end
    cycle(1'b0, 1'b1, OPC_ST, 64'h4010, 1'b0, '0);
    n_cmp++;
    if (overflow_cnt_o !== 16'd1) begin
      n_err++; $display("FAIL flush_then_overflow: got %0d want 1", overflow_cnt_o);
    end
  endtask

  task automatic test_unmonitored();
    cycle(1'b1, 1'b0, 7'd0, '0, 1'b0, '0);
    cycle(1'b0, 1'b1, OPC_R, 64'h5000, 1'b0, '0);
    n_cmp++;
    if ({grant_valid_o, lane_busy_o} !== {1'b0, 4'b0000}) begin
      n_err++; $display("FAIL unmonitored: gv=%0b busy=%b want 0 0000", grant_valid_o, lane_busy_o);
    end
    cycle(1'b0, 1'b1, OPC_LD, 64'h5004, 1'b0, '0);
    cycle(1'b1, 1'b1, OPC_LD, 64'h5008, 1'b0, '0);
    n_cmp++;
    if ({grant_valid_o, grant_lane0_o, grant_slot0_o, grant_two_lane_o, grant_lane1_o, grant_last_o,
         grant_itype_o, grant_pc_o, lane_busy_o, overflow_cnt_o} !== '0) begin
      n_err++; $display("FAIL midreset: gv=%0b itype=%0d pc=%0h busy=%b ovf=%0d want all 0",
                        grant_valid_o, grant_itype_o, grant_pc_o, lane_busy_o, overflow_cnt_o);
    end
  endtask

  task automatic test_random();
    logic [6:0]    opc;
    logic [NL-1:0] rel;
    logic [FW-1:0] obs, exp;
    bit v, fl, rst;
    cycle(1'b1, 1'b0, 7'd0, '0, 1'b0, '0);
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: opc = OPC_LD;
        1: opc = OPC_ST;
        2: opc = OPC_R;
        default: opc = 7'($urandom);
      endcase
      v   = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 9) == 0);
      rel = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
      rst = ($urandom_range(0, 149) == 0);
      cycle(rst, v, opc, {32'($urandom), 32'($urandom)}, fl, rel);
      n_cmp++;
      if (obs_ready !== exp_ready) begin
        n_err++; $display("FAIL rand_ready[%0d]: got %0b want %0b", n, obs_ready, exp_ready);
      end
      n_cmp++;
      if (grant_valid_o !== e_gv) begin
        n_err++; $display("FAIL rand_gv[%0d]: got %0b want %0b", n, grant_valid_o, e_gv);
      end
      if (e_gv) begin
        obs = {grant_lane0_o, grant_slot0_o, grant_two_lane_o, grant_lane1_o, grant_last_o,
               grant_itype_o, grant_pc_o};
        exp = {LW'(e_l0), SWW'(e_s0), e_two, LW'(e_l1), e_last, 2'(e_itype), e_pc};
        n_cmp++;
        if (obs !== exp) begin
          n_err++; $display("FAIL rand_grant[%0d]: got %0h want %0h", n, obs, exp);
        end
      end
      n_cmp++;
      if ({lane_busy_o, overflow_cnt_o} !== {m_busy(), 16'(m_ovf)}) begin
        n_err++; $display("FAIL rand_state[%0d]: busy=%b ovf=%0d want %b %0d",
                          n, lane_busy_o, overflow_cnt_o, m_busy(), m_ovf);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_store();
    test_fill_lanes();
    test_release_reuse();
    test_deferred_release();
    test_flush();
    test_unmonitored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rm_slot_allocator.md
Name: rm_slot_allocator

Overview:
- Parametrised successor to the runtime-monitor lane allocator.
- Assigns each monitored load/store entering the issue queue to a slot in one of NUM_LANES monitor lanes. Each lane holds SLOTS_PER_LANE consecutive instructions.
- Consecutive windows overlap: the instruction that fills a lane's last slot also opens the next lane at slot 0.
- Sits between the issue-queue enqueue point and the runtime-monitor lanes. Adds a ready/valid handshake, registered grants, deferred releases and overflow accounting.

Parameters:
NUM_LANES, 4, number of monitor lanes (>=2)
SLOTS_PER_LANE, 2, instructions per lane window (>=2)
VLEN, riscv::VLEN, PC width
MON_LOAD, 1, monitor riscv::OpcodeLoad when 1
MON_STORE, 1, monitor riscv::OpcodeStore when 1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  instruction enqueued this cycle
req_ready_o  out  1  allocator can accept a monitored instruction
req_opcode_i  in  7  instruction opcode
req_pc_i  in  VLEN  instruction PC
flush_i  in  1  pipeline flush
lane_release_i  in  NUM_LANES  one-hot-or-more lane release from monitors
grant_valid_o  out  1  registered grant valid
grant_lane0_o  out  clog2(NUM_LANES)  primary lane
grant_slot0_o  out  clog2(SLOTS_PER_LANE)  slot within primary lane
grant_two_lane_o  out  1  instruction also opened a new lane
grant_lane1_o  out  clog2(NUM_LANES)  newly opened lane (slot 0)
grant_last_o  out  1  instruction sealed primary lane
grant_itype_o  out  ariane_pkg::monitored_itype  SW_RM or LW_RM
grant_pc_o  out  VLEN  PC of granted instruction
lane_busy_o  out  NUM_LANES  lane not FREE
overflow_cnt_o  out  16  cycles a monitored request was refused (saturating)

Behaviour:
- Monitored request = req_valid_i & opcode enabled by MON_LOAD/MON_STORE. Unmonitored requests are ignored and produce no grant. Accepted request = monitored & req_ready_o & ~flush_i.
- Per-lane FSM: FREE -> FILLING on slot-0 allocation; FILLING -> SEALED when its last slot is allocated; FILLING/SEALED -> FREE on release. Each lane keeps a slot count register.
- Open-lane register open_vld/open_lane. At most one lane is FILLING at any time.
- Allocation of an accepted request, using registered state only:
  - No open lane: lowest-index FREE lane L, slot 0, count=1; L becomes FILLING and open_lane=L.
  - Open lane O with count < SLOTS_PER_LANE-1: slot=count, count+1.
  - Open lane O with count == SLOTS_PER_LANE-1: slot SLOTS_PER_LANE-1, O becomes SEALED, grant_last_o=1. Lowest FREE lane N is opened at slot 0, open_lane=N, grant_two_lane_o=1, grant_lane1_o=N.
- req_ready_o is combinational from registered state only (no path from lane_release_i). It is 1 if the chosen case needs no new lane, or if at least one FREE lane exists.
- Grant latency: outputs are registered one cycle after acceptance. grant_valid_o pulses for exactly 1 cycle. grant_valid_o is 0 in any cycle following a cycle with flush_i=1.
- Release: lane goes FREE and its count clears next cycle; open_vld clears if open_lane is released. A freed lane is allocatable from the following cycle.
- Release of a lane targeted by an accepted request in the same cycle is deferred into pending_release and applied the next cycle; the allocation completes first. Release of a FREE lane is a no-op.
- overflow_cnt_o increments each cycle with a monitored request, ~flush_i and ~req_ready_o; it saturates at 0xFFFF.
- Reset (rst_i=1 at clk_i edge):
  - All lanes FREE, counts 0, open_vld=0, pending_release=0.
  - All grant_* outputs 0, lane_busy_o=0, overflow_cnt_o=0.
  - Reset has priority over all other inputs.

Optional Feature:
RM_SLOT_ALLOC_PERF_EN
- Defined: adds outputs perf_alloc_cnt_o[31:0], counting accepted monitored requests (wrapping), and perf_two_lane_cnt_o[31:0], counting grants with grant_two_lane_o=1 (wrapping). Both clear on rst_i.
- Undefined: both ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then one store (opcode 0100011) at PC 0x80000000 -> next cycle grant_valid_o=1, lane0=0, slot0=0, two_lane=0, itype=SW_RM, lane_busy_o=0001.
- Defaults, 4 back-to-back loads -> grants (0,0,two=0), (0,1,lane1=1), (1,1,lane1=2), (2,1,lane1=3); lane_busy_o=1111; 5th load sees req_ready_o=0 and overflow_cnt_o becomes 1.
- Full state from previous test, lane_release_i=0001 -> lane_busy_o=1110 next cycle; following load granted lane0=3, slot1, lane1=0.
- Accepted load targeting open lane 1 while lane_release_i=0010 in the same cycle -> grant completes; lane 1 is FREE two cycles later, not one.
- flush_i=1 with a monitored request -> no grant, no state change, overflow_cnt_o unchanged.
- Unmonitored opcode (0110011) with req_valid_i=1 -> grant_valid_o stays 0; rst_i asserted mid-sequence -> all outputs 0 next cycle.
